// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and the
// fixed 8N1 frame shape (1 start bit, 8 data bits, no parity, 1 stop bit).
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int START_BITS  = 1;
    localparam int DATA_BITS   = 8;
    localparam int PARITY_BITS = 0;
    localparam int STOP_BITS   = 1;
    localparam int FRAME_BITS  = START_BITS + DATA_BITS + PARITY_BITS + STOP_BITS;

    // Bit-period counter is wide enough for the largest legal CLK_DIV.
    localparam int CNT_W     = 16;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO used when UART_RX_FIFO_EN is defined.
// A push while full is accepted only if a pop happens on the same edge.
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == OCC_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head entry shows with no read latency; forced to zero while empty.
    assign dout = empty ? 8'h00 : mem[rd_ptr];

    // Storage array write port.
    // NOTE: the storage array has no reset; empty gates dout, so stale
    // contents are never visible and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, oversampled by CLK_DIV clocks per bit.
// Define UART_RX_FIFO_EN to buffer received bytes in a FIFO_DEPTH-entry
// FIFO; otherwise a single holding register is used.
module uart_rx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] data,
    output logic       valid,
    output logic       overrun,
    output logic       frame_err
);

    import uart_rx_pkg::*;

    if (CLK_DIV < 4 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("uart_rx: CLK_DIV out of range 4..65535");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be a power of two, at least 2");
    end

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    logic                 sync1, sync2, sync_prev;
    rx_state_t            state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BIT_IDX_W-1:0] bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 push, ferr_n, expire;
    logic                 pop, buf_empty, buf_full;
    logic [7:0]           buf_data;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    // NOTE: non-blocking assignments let every flop sample the old value of
    // its neighbour, which is what makes this a shift chain and not a wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= rx;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // Decoder state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            frame_err <= ferr_n;
        end
    end

    assign expire = (cnt == '0);

    // Next-state logic: mid-bit sampling driven by the bit-period counter.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        push      = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            IDLE: begin
                if (sync_prev && !sync2) begin
                    state_n = START;
                    cnt_n   = HALF_BIT;
                end
            end
            START: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else if (!sync2) begin
                    state_n   = DATA;
                    cnt_n     = FULL_BIT;
                    bit_idx_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shreg_n = {sync2, shreg[DATA_BITS-1:1]};
                    cnt_n   = FULL_BIT;
                    if (bit_idx == LAST_BIT) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else if (sync2) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end else begin
                    ferr_n  = 1'b1;
                    state_n = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (sync2) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign pop = rd && !buf_empty;

`ifdef UART_RX_FIFO_EN
    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (shreg),
        .dout  (buf_data),
        .empty (buf_empty),
        .full  (buf_full)
    );
`else
    logic hold_full;

    // Single holding register: refilled when empty or when drained this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            buf_data  <= '0;
        end else if (push && (!hold_full || pop)) begin
            hold_full <= 1'b1;
            buf_data  <= shreg;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end

    assign buf_empty = !hold_full;
    assign buf_full  = hold_full;
`endif

    // Overrun flags a good byte lost because the buffer could not take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else begin
            overrun <= push && buf_full && !pop;
        end
    end

    assign data  = buf_data;
    assign valid = !buf_empty;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clk cycles per bit; legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: receive buffer entries; power of 2, at least 2; used only with UART_RX_FIFO_EN.
REQ-003 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port rx, input, 1: serial line (machine uart_tx); idle high; asynchronous to clk.
REQ-006 SHALL have port rd, input, 1: pop request; acts only when valid=1.
REQ-007 SHALL have port data, output, 8: oldest received byte; meaningful only while valid=1.
REQ-008 SHALL have port valid, output, 1: buffer non-empty.
REQ-009 SHALL have port overrun, output, 1: one-cycle pulse when a good byte is dropped because the buffer is full.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse on a bad stop bit.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: a synchronized 1->0 transition SHALL enter START and load the bit counter with CLK_DIV/2-1.
REQ-014 START: at counter expiry (mid-bit), line 0 SHALL enter DATA with counter CLK_DIV-1; line 1 is a false start and SHALL return to IDLE.
REQ-015 DATA: SHALL sample 8 bits LSB first, one per CLK_DIV cycles at mid-bit, then enter STOP.
REQ-016 STOP: at mid-bit, line 1 SHALL push the byte and return to IDLE; line 0 SHALL pulse frame_err, discard the byte and enter WAIT_HIGH.
REQ-017 WAIT_HIGH: SHALL return to IDLE only after the synchronized line reads 1.
REQ-018 A push SHALL make data/valid visible on the cycle after the stop-bit sample.
REQ-019 data SHALL be first-word-fall-through: it shows the head entry with no read latency; rd with valid=1 advances it on the next edge.
REQ-020 rd while valid=0 SHALL be ignored, with no state change.
REQ-021 A push while full with no simultaneous pop SHALL drop the new byte, pulse overrun and keep the buffer contents.
REQ-022 Simultaneous push and pop while full SHALL both succeed, with no overrun.
REQ-023 Buffer pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, counters 0, buffer empty, valid=0, data=0, overrun=0, frame_err=0, and synchronizer flops to 1.
REQ-025 Reset mid-frame SHALL discard the partial byte; after release, decoding SHALL begin only at the next falling edge.

Configuration
REQ-026 Macro UART_RX_FIFO_EN defined: the buffer SHALL be a FIFO_DEPTH-entry FIFO.
REQ-027 Macro UART_RX_FIFO_EN undefined: the buffer SHALL be a single holding register, i.e. depth 1 with the same full/overrun/simultaneous-event rules, and FIFO_DEPTH ignored.

Structure
REQ-028 The shared definitions file SHALL hold the state encodings and the frame constants (8 data bits, 1 start bit, 1 stop bit, no parity).
REQ-029 The buffer SHALL be sub-module uart_rx_fifo (push, pop, din, dout, empty, full), instantiated only with UART_RX_FIFO_EN.

Verification (CLK_DIV=16, FIFO_DEPTH=8 unless stated)
REQ-030 Send 0x55 framed, rd=0 -> valid rises 2+16*9.5 (+/-1) cycles after the start edge; data=0x55; no error pulses.
REQ-031 Drive rx low for 4 cycles, then high -> no push, state back to IDLE, valid stays 0.
REQ-032 Send 0xA3 with stop bit 0 -> one frame_err pulse, valid stays 0; the next good byte 0x3C is received after the line returns high.
REQ-033 Send 0x01..0x09 with rd=0 -> overrun pulses on the 9th byte only; rd then pops 0x01..0x08 in order, then valid=0.
REQ-034 Assert rst_n=0 during bit 4 of 0xFF, release, send 0x12 -> only 0x12 is received.
REQ-035 Build without UART_RX_FIFO_EN, send 0x11 then 0x22 with rd=0 -> data=0x11, one overrun pulse; rd then valid=0.
